// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder: RV32I width codes,
// responder states and byte-lane geometry.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int LANES = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Width codes with no RV32I meaning, plus unsigned widths on stores.
    function automatic logic f3_illegal(input logic write, input logic [2:0] funct3);
        logic bad;
        bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        return bad || (write && funct3[2]);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the MEM stage (master) and the data-memory
// responder (slave).
interface dmem_responder_if;

    // A transfer happens on a rising edge where valid && ready are both 1.
    // The sender holds its payload steady while valid is 1 and not yet taken.
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_align.sv
// Byte-lane steering for RV32I loads and stores: store enables/replicated data
// and misalignment, and load lane extraction with sign or zero extension.
module dmem_align
    import dmem_pkg::*;
(
    input  logic [1:0]       addr_lo,
    input  logic [2:0]       funct3,
    input  logic [31:0]      wdata,
    input  logic [31:0]      rword,
    output logic [LANES-1:0] be,
    output logic [31:0]      wdata_sh,
    output logic             misalign,
    output logic [31:0]      rdata_ext
);

    logic [31:0] rshift;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        be       = '0;
        wdata_sh = wdata;
        misalign = 1'b0;
        // Replicating the data across lanes lets the enables alone pick the target bytes.
        case (funct3)
            F3_B, F3_BU: begin
                be       = LANES'(1) << addr_lo;
                wdata_sh = {4{wdata[7:0]}};
            end
            F3_H, F3_HU: begin
                be       = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_sh = {2{wdata[15:0]}};
                misalign = addr_lo[0];
            end
            F3_W: begin
                be       = 4'b1111;
                misalign = (addr_lo != 2'b00);
            end
            default: be = '0;
        endcase
    end

    always_comb begin
        rshift    = rword >> {addr_lo, 3'b000};
        rbyte     = rshift[7:0];
        rhalf     = addr_lo[1] ? rword[31:16] : rword[15:0];
        rdata_ext = '0;
        case (funct3)
            F3_B:    rdata_ext = {{24{rbyte[7]}}, rbyte};
            F3_BU:   rdata_ext = {24'h0, rbyte};
            F3_H:    rdata_ext = {{16{rhalf[15]}}, rhalf};
            F3_HU:   rdata_ext = {16'h0, rhalf};
            F3_W:    rdata_ext = rword;
            default: rdata_ext = '0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits a fixed number
// of cycles, performs the byte/half/word access and returns data or an error.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 10,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus,
    output logic             busy,
    output state_t           dbg_state
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            wr_q;
    logic [2:0]      f3_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic            err_q;
    logic [31:0]     rdata_q;
    logic            rerr_q;

    logic            in_idle;
    logic            accept;
    logic            do_access;
    logic            acc_write;
    logic [2:0]      acc_f3;
    logic [31:0]     acc_addr;
    logic [31:0]     acc_wdata;
    logic            acc_err;
    logic            err_now;
    logic [31:0]     off;
    logic            range_err;
    logic [ADDR_WIDTH-1:0] widx;
    logic [31:0]     rword;
    logic [LANES-1:0] be;
    logic [31:0]     wdata_sh;
    logic            misalign;
    logic [31:0]     rdata_ext;

    logic [31:0]     mem [0:DEPTH-1];

    assign in_idle        = (state_q == ST_IDLE);
    assign bus.req_ready  = in_idle;
    assign accept         = bus.req_valid && in_idle;
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = rerr_q;
    assign busy           = !in_idle;
    assign dbg_state      = state_q;

    // In IDLE the live request drives the datapath so errors (and a zero-wait
    // access) are evaluated on the accept cycle; later the latched copy is used.
    assign acc_write = in_idle ? bus.req_write  : wr_q;
    assign acc_f3    = in_idle ? bus.req_funct3 : f3_q;
    assign acc_addr  = in_idle ? bus.req_addr   : addr_q;
    assign acc_wdata = in_idle ? bus.req_wdata  : wdata_q;

    // Unsigned offset: addresses below BASE_ADDR wrap high and land out of range.
    assign off       = acc_addr - BASE_ADDR;
    assign range_err = |off[31:ADDR_WIDTH+2];
    assign widx      = off[ADDR_WIDTH+1:2];
    assign rword     = mem[widx];

    dmem_align u_align (
        .addr_lo   (off[1:0]),
        .funct3    (acc_f3),
        .wdata     (acc_wdata),
        .rword     (rword),
        .be        (be),
        .wdata_sh  (wdata_sh),
        .misalign  (misalign),
        .rdata_ext (rdata_ext)
    );

    assign err_now = range_err || misalign || f3_illegal(acc_write, acc_f3);
    assign acc_err = in_idle ? err_now : err_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        do_access = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d   = ST_RESP;
                        do_access = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d   = ST_RESP;
                    do_access = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                wr_q    <= bus.req_write;
                f3_q    <= bus.req_funct3;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                err_q   <= err_now;
            end
            if (do_access) begin
                rdata_q <= (acc_err || acc_write) ? 32'h0 : rdata_ext;
                rerr_q  <= acc_err;
            end else if ((state_q == ST_RESP) && bus.resp_ready) begin
                rdata_q <= '0;
                rerr_q  <= 1'b0;
            end
        end
    end

    // The array has no reset; gating with reset keeps a store from landing while it is held.
    always_ff @(posedge clk) begin
        if (reset && do_access && acc_write && !acc_err) begin
            for (int k = 0; k < LANES; k++) begin
                if (be[k]) mem[widx][8*k +: 8] <= wdata_sh[8*k +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed and randomized load/store sequences against the data-memory
// responder, with a queue of expected {err, rdata} responses.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int WAIT_CYCLES = 2;

    logic   clk;
    logic   reset;
    logic   busy;
    state_t dbg_state;

    int checks = 0;
    int errors = 0;

    logic [32:0] exp_q[$];
    logic [7:0]  mdl [0:15];

    dmem_responder_if bus ();

    dmem_responder #(
        .ADDR_WIDTH  (10),
        .WAIT_CYCLES (WAIT_CYCLES),
        .BASE_ADDR   (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic txn(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic e, input logic [31:0] rd,
                       input int hold);
        int waited;
        int lat;
        logic [32:0] exp;
        exp_q.push_back({e, rd});
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        waited = 0;
        while (!bus.req_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        check("req_ready_before_accept", 33'(bus.req_ready), 33'd1);
        @(posedge clk); #1;
        bus.req_valid = (hold > 0);
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        lat = 0;
        while (!bus.resp_valid && lat < 20) begin
            check("req_ready_low_wait", 33'(bus.req_ready), 33'd0);
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 33'(lat), 33'(WAIT_CYCLES));
        check("busy_in_resp", 33'(busy), 33'd1);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 33'd1, 33'd0);
            exp = '0;
        end else begin
            exp = exp_q.pop_front();
        end
        check("resp_rdata", 33'(bus.resp_rdata), 33'(exp[31:0]));
        check("resp_err", 33'(bus.resp_err), 33'(exp[32]));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 33'(bus.resp_valid), 33'd1);
            check("hold_rdata", 33'(bus.resp_rdata), 33'(exp[31:0]));
            check("hold_err", 33'(bus.resp_err), 33'(exp[32]));
            check("hold_req_ready", 33'(bus.req_ready), 33'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        bus.req_valid  = 1'b0;
        check("post_valid", 33'(bus.resp_valid), 33'd0);
        check("post_rdata", 33'(bus.resp_rdata), 33'd0);
        check("post_err", 33'(bus.resp_err), 33'd0);
        check("post_req_ready", 33'(bus.req_ready), 33'd1);
        check("post_state", 33'(dbg_state), 33'(ST_IDLE));
    endtask

    function automatic logic [31:0] mdl_load(input logic [2:0] f3, input int o);
        logic [31:0] r;
        case (f3)
            F3_B:    r = {{24{mdl[o][7]}}, mdl[o]};
            F3_BU:   r = {24'h0, mdl[o]};
            F3_H:    r = {{16{mdl[o+1][7]}}, mdl[o+1], mdl[o]};
            F3_HU:   r = {16'h0, mdl[o+1], mdl[o]};
            default: r = {mdl[o+3], mdl[o+2], mdl[o+1], mdl[o]};
        endcase
        return r;
    endfunction

    task automatic mdl_store(input logic [2:0] f3, input int o, input logic [31:0] wd);
        mdl[o] = wd[7:0];
        if (f3 != F3_B) mdl[o+1] = wd[15:8];
        if (f3 == F3_W) begin
            mdl[o+2] = wd[23:16];
            mdl[o+3] = wd[31:24];
        end
    endtask

    initial begin
        logic [31:0] wd;
        logic [2:0]  f3;
        int          o;
        reset          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 33'(bus.req_ready), 33'd1);
        check("rst_resp_valid", 33'(bus.resp_valid), 33'd0);
        check("rst_rdata", 33'(bus.resp_rdata), 33'd0);
        check("rst_err", 33'(bus.resp_err), 33'd0);
        check("rst_busy", 33'(busy), 33'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Word store/load and lane extraction from 0xDEADBEEF.
        txn(1, F3_W,  32'h100, 32'hDEADBEEF, 0, 32'h0, 0);
        txn(0, F3_W,  32'h100, 32'h0,        0, 32'hDEADBEEF, 0);
        txn(0, F3_B,  32'h103, 32'h0,        0, 32'hFFFFFFDE, 0);
        txn(0, F3_BU, 32'h103, 32'h0,        0, 32'h000000DE, 0);
        txn(0, F3_H,  32'h102, 32'h0,        0, 32'hFFFFDEAD, 0);
        txn(0, F3_HU, 32'h100, 32'h0,        0, 32'h0000BEEF, 0);

        // Partial stores merge into the existing word.
        txn(1, F3_B,  32'h101, 32'h00000012, 0, 32'h0, 0);
        txn(1, F3_H,  32'h102, 32'h00005566, 0, 32'h0, 0);
        txn(0, F3_W,  32'h100, 32'h0,        0, 32'h556612EF, 0);

        // Error cases; the failed store must leave memory alone.
        txn(0, F3_W,  32'h102, 32'h0,        1, 32'h0, 0);
        txn(1, F3_H,  32'h101, 32'hFFFFFFFF, 1, 32'h0, 0);
        txn(0, F3_W,  32'h100, 32'h0,        0, 32'h556612EF, 0);
        txn(0, F3_W,  32'h1000, 32'h0,       1, 32'h0, 0);
        txn(0, 3'b011, 32'h100, 32'h0,       1, 32'h0, 0);
        txn(0, 3'b111, 32'h100, 32'h0,       1, 32'h0, 0);
        txn(1, F3_BU, 32'h104, 32'h000000AA, 1, 32'h0, 0);
        txn(1, F3_W,  32'h0FFC, 32'h13579BDF, 0, 32'h0, 0);
        txn(0, F3_W,  32'h0FFC, 32'h0,       0, 32'h13579BDF, 0);

        // Back-pressure on the response with a request waiting behind it.
        txn(0, F3_W,  32'h100, 32'h0,        0, 32'h556612EF, 5);
        txn(0, F3_HU, 32'h102, 32'h0,        0, 32'h00005566, 0);

        // Reset while a store is still waiting: the store must never land.
        txn(1, F3_W,  32'h200, 32'h00000000, 0, 32'h0, 0);
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_funct3 = F3_W;
        bus.req_addr   = 32'h200;
        bus.req_wdata  = 32'hCAFEF00D;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("accepted_to_wait", 33'(dbg_state), 33'(ST_WAIT));
        reset = 1'b0;
        #1;
        check("midrst_req_ready", 33'(bus.req_ready), 33'd1);
        check("midrst_resp_valid", 33'(bus.resp_valid), 33'd0);
        check("midrst_busy", 33'(busy), 33'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("after_rst_req_ready", 33'(bus.req_ready), 33'd1);
        check("after_rst_resp_valid", 33'(bus.resp_valid), 33'd0);
        check("after_rst_busy", 33'(busy), 33'd0);
        txn(0, F3_W, 32'h200, 32'h0, 0, 32'h00000000, 0);

        // Randomized traffic over a 16-byte window checked against a byte model.
        for (int i = 0; i < 4; i++) begin
            wd = $urandom;
            mdl_store(F3_W, 4 * i, wd);
            txn(1, F3_W, 32'h300 + 32'(4 * i), wd, 0, 32'h0, 0);
        end
        for (int i = 0; i < 30; i++) begin
            wd = $urandom;
            o  = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) begin
                case ($urandom_range(0, 2))
                    0:       f3 = F3_B;
                    1:       f3 = F3_H;
                    default: f3 = F3_W;
                endcase
                if (f3 == F3_H) o = o & ~1;
                if (f3 == F3_W) o = o & ~3;
                mdl_store(f3, o, wd);
                txn(1, f3, 32'h300 + 32'(o), wd, 0, 32'h0, 0);
            end else begin
                case ($urandom_range(0, 4))
                    0:       f3 = F3_B;
                    1:       f3 = F3_BU;
                    2:       f3 = F3_H;
                    3:       f3 = F3_HU;
                    default: f3 = F3_W;
                endcase
                if (f3 == F3_H || f3 == F3_HU) o = o & ~1;
                if (f3 == F3_W) o = o & ~3;
                txn(0, f3, 32'h300 + 32'(o), 32'h0, 0, mdl_load(f3, o), 0);
            end
        end

        check("scoreboard_drained", 33'(exp_q.size()), 33'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
